mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the byte-addressed unified memory.
- Accepts one RV32 load/store request at a time from the execute stage. Decodes funct3 into memory size and sign controls, and checks legality and alignment.
- Drives the memory data-port strobes for exactly one cycle, samples the bidirectional data bus, and returns a held response to the writeback stage.
- Never touches the instruction port.

Parameters:
- ADDR_W, 20, physical memory address width; legal byte addresses are 0 .. 2^ADDR_W-1.
- CHECK_ALIGN, 1, 1 = halfword/word accesses must be naturally aligned; 0 = misalignment permitted.

Ports:
- CLK  input  1  system clock; unit state updates on posedge, memory samples on negedge.
- RST  input  1  asynchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  unit can accept a request.
- REQ_WE  input  1  1 = store, 0 = load.
- REQ_FUNCT3  input  3  RV32 funct3 of the load/store.
- REQ_ADDR  input  32  effective byte address.
- REQ_WDATA  input  32  store data; low bytes used for SB/SH.
- RESP_VALID  output  1  response present.
- RESP_READY  input  1  consumer accepts response.
- RESP_RDATA  output  32  load result, already extended by memory; 0 for stores and errors.
- RESP_ERR  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- MEM_CS  output  1  memory chip select.
- MEM_WE  output  1  memory write enable.
- MEM_ADDR  output  ADDR_W  memory data address.
- MEM_SIZE  output  2  00 byte, 01 halfword, 10 word.
- MEM_SIGNED  output  1  1 = sign-extend load.
- MEM_DATA  inout  32  memory data bus.

Behaviour:
- Reset (async, RST=1): state IDLE; REQ_READY=0 while RST high, then 1; RESP_VALID=0; RESP_RDATA=0; RESP_ERR=00; MEM_CS=0; MEM_WE=0; MEM_ADDR=0; MEM_SIZE=10; MEM_SIGNED=0; MEM_DATA released (Z). All memory-side outputs are registers.
- States:
  - IDLE: REQ_READY=1. On REQ_VALID, latch the request and decode it. Go to ACCESS if legal, otherwise RESP with the error code.
  - ACCESS: exactly one cycle. MEM_CS=1, MEM_WE=REQ_WE, MEM_ADDR=REQ_ADDR[ADDR_W-1:0], MEM_SIZE/MEM_SIGNED from decode.
    - Store: MEM_DATA driven with latched wdata for the whole cycle.
    - Load: MEM_DATA is Z.
    - At the closing posedge, loads capture MEM_DATA into RESP_RDATA; stores set RESP_RDATA=0. Then go to RESP and deassert MEM_CS/MEM_WE.
  - RESP: RESP_VALID=1; RESP_RDATA and RESP_ERR are held stable. On RESP_READY, go to IDLE. REQ_READY=0 here, so there is no overlap.
- Latency: request accept edge to RESP_VALID high is 2 cycles for a legal access and 1 cycle for an errored one. Throughput is at most 1 access per 3 cycles.
- Decode:
  - Loads: 000 → byte/signed; 001 → half/signed; 010 → word; 100 → byte/unsigned; 101 → half/unsigned.
  - Stores: 000/001/010 → byte/half/word.
  - All other funct3 values are illegal, including any store funct3 ≥ 011.
- Error priority: illegal (11) > misaligned (01) > out of range (10).
  - Misaligned (CHECK_ALIGN=1 only): half with addr[0]=1; word with addr[1:0]≠00.
  - Out of range: REQ_ADDR[31:ADDR_W]≠0, or addr + bytes - 1 exceeds 2^ADDR_W-1. No wraparound is permitted.
  - Errored requests never assert MEM_CS, so memory is unmodified.
- Bus rule: the unit drives MEM_DATA only while MEM_CS&MEM_WE is registered high. There is never contention with memory, which drives the bus only when CS=1 and WE=0.
- Reset mid-operation: RST asserted during ACCESS forces MEM_CS/MEM_WE low before the next negedge, so no partial store is committed. A pending response is discarded.
- Simultaneous REQ_VALID during RESP is ignored; REQ_READY=0 applies.

Decomposition:
- Shared package holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - MEM_SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - RESP_ERR codes (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL);
  - the state enumeration.
- One combinational sub-module, mem_access_decode: funct3 + addr + we → size, signed, err. The top level holds the FSM, registers and tristate.

Test Plan:
- Store then load, legal:
  - SW 0xDEADBEEF at 0x00100 → memory bytes 0x100..0x103 = EF BE AD DE.
  - Then LW 0x00100 → RESP_VALID 2 cycles after accept, RESP_RDATA=0xDEADBEEF, RESP_ERR=00.
- Sign/zero extension: SB 0x80 at 0x00200.
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - SH 0x8001 then LH → 0xFFFF8001, LHU → 0x00008001.
- Misaligned LW 0x00102 with CHECK_ALIGN=1 → RESP_VALID 1 cycle after accept, RESP_ERR=01, MEM_CS never high. With CHECK_ALIGN=0 → ERR=00 and correct data.
- Range and illegal:
  - LW 0x00100000 → ERR=10.
  - LW 0x000FFFFE with CHECK_ALIGN=0 → ERR=10.
  - funct3=011 load → ERR=11.
  - Store funct3=100 → ERR=11.
  - Memory unchanged in all cases.
- Backpressure: hold RESP_READY=0 for 5 cycles → RESP_VALID/RDATA stable, REQ_READY=0, a new REQ_VALID is ignored. Release → one-cycle handshake, return to IDLE.
- Reset mid-store: assert RST during the ACCESS cycle of SW 0x12345678 to 0x00300 → MEM_CS low before the negedge, bytes at 0x300 remain 0, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store front end: funct3 codes, memory size
// codes, response error codes and the control state enumeration.
package mem_access_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    // Offset of the last byte touched by an access of the given size.
    function automatic logic [2:0] size_span(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_span = 3'd0;
            SZ_HALF: size_span = 3'd1;
            default: size_span = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_decode.sv
// Combinational funct3/address decode: access size, sign control and the
// prioritised error code (illegal > misaligned > out of range).
module mem_access_decode
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [1:0]  size,
    output logic        sign_ext,
    output logic [1:0]  err
);

    logic        legal;
    logic        misalign;
    logic        out_of_range;
    logic [32:0] last_byte;

    always_comb begin
        legal    = 1'b1;
        size     = SZ_WORD;
        sign_ext = 1'b0;
        if (we) begin
            case (funct3)
                SB:      size = SZ_BYTE;
                SH:      size = SZ_HALF;
                SW:      size = SZ_WORD;
                default: legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                LB:      begin size = SZ_BYTE; sign_ext = 1'b1; end
                LH:      begin size = SZ_HALF; sign_ext = 1'b1; end
                LW:      size = SZ_WORD;
                LBU:     size = SZ_BYTE;
                LHU:     size = SZ_HALF;
                default: legal = 1'b0;
            endcase
        end
    end

    assign misalign = CHECK_ALIGN &&
                      (((size == SZ_HALF) && addr[0]) ||
                       ((size == SZ_WORD) && (addr[1:0] != 2'b00)));

    // One extra bit so an access running past 2^32 cannot wrap back in range.
    assign last_byte    = {1'b0, addr} + {30'b0, size_span(size)};
    assign out_of_range = |last_byte[32:ADDR_W];

    always_comb begin
        if (!legal)            err = ERR_ILLEGAL;
        else if (misalign)     err = ERR_MISALIGN;
        else if (out_of_range) err = ERR_RANGE;
        else                   err = ERR_NONE;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding RV32 load/store front end: decode, one-cycle memory
// strobe on the data port, held response towards writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RESP_VALID,
    input  logic              RESP_READY,
    output logic [31:0]       RESP_RDATA,
    output logic [1:0]        RESP_ERR,
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGNED,
    inout  wire  [31:0]       MEM_DATA
);

    state_t              state_q, state_d;
    logic                cs_d, we_d, signed_d, resp_valid_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [1:0]          size_d, err_d;
    logic [31:0]         rdata_d, wdata_q, wdata_d;

    logic [1:0]          dec_size, dec_err;
    logic                dec_signed;

    mem_access_decode #(
        .ADDR_W      (ADDR_W),
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_decode (
        .we       (REQ_WE),
        .funct3   (REQ_FUNCT3),
        .addr     (REQ_ADDR),
        .size     (dec_size),
        .sign_ext (dec_signed),
        .err      (dec_err)
    );

    assign REQ_READY = (state_q == S_IDLE) && !RST;

    // Bus is only driven from registered strobes, so reset releases it at once.
    assign MEM_DATA = (MEM_CS && MEM_WE) ? wdata_q : 32'bz;

    always_comb begin
        state_d      = state_q;
        cs_d         = MEM_CS;
        we_d         = MEM_WE;
        addr_d       = MEM_ADDR;
        size_d       = MEM_SIZE;
        signed_d     = MEM_SIGNED;
        wdata_d      = wdata_q;
        resp_valid_d = RESP_VALID;
        rdata_d      = RESP_RDATA;
        err_d        = RESP_ERR;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    err_d   = dec_err;
                    rdata_d = '0;
                    wdata_d = REQ_WDATA;
                    if (dec_err == ERR_NONE) begin
                        state_d  = S_ACCESS;
                        cs_d     = 1'b1;
                        we_d     = REQ_WE;
                        addr_d   = REQ_ADDR[ADDR_W-1:0];
                        size_d   = dec_size;
                        signed_d = dec_signed;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                state_d      = S_RESP;
                cs_d         = 1'b0;
                we_d         = 1'b0;
                resp_valid_d = 1'b1;
                rdata_d      = MEM_WE ? '0 : MEM_DATA;
            end
            S_RESP: begin
                if (RESP_READY) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            MEM_CS     <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_SIZE   <= SZ_WORD;
            MEM_SIGNED <= 1'b0;
            wdata_q    <= '0;
            RESP_VALID <= 1'b0;
            RESP_RDATA <= '0;
            RESP_ERR   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            MEM_CS     <= cs_d;
            MEM_WE     <= we_d;
            MEM_ADDR   <= addr_d;
            MEM_SIZE   <= size_d;
            MEM_SIGNED <= signed_d;
            wdata_q    <= wdata_d;
            RESP_VALID <= resp_valid_d;
            RESP_RDATA <= rdata_d;
            RESP_ERR   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Two units (alignment checked / unchecked) share one stimulus stream; each has
// its own byte memory, reference image and response scoreboard.
module tb_mem_access_unit;

    localparam int ADDR_W    = 20;
    localparam int MEM_BYTES = 1 << ADDR_W;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          cs;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b0;

    logic              req_ready  [2];
    logic              resp_valid [2];
    logic [31:0]       resp_rdata [2];
    logic [1:0]        resp_err   [2];
    logic              mem_cs     [2];
    logic              mem_we     [2];
    logic [ADDR_W-1:0] mem_addr   [2];
    logic [1:0]        mem_size   [2];
    logic              mem_signed [2];
    logic [31:0]       bus_in     [2];

    logic [7:0] mem [2][MEM_BYTES];
    logic [7:0] ref_mem [longint];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rr_mode = 0;
    int   cs_cnt [2];
    bit   seen [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_read(input int k, input logic [ADDR_W-1:0] a,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] w;
        w = {mem[k][ADDR_W'(a + 3)], mem[k][ADDR_W'(a + 2)], mem[k][ADDR_W'(a + 1)], mem[k][a]};
        case (sz)
            2'd0:    return sg ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            2'd1:    return sg ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        wire [31:0] bus;
        mem_access_unit #(.ADDR_W(ADDR_W), .CHECK_ALIGN(k == 0)) u_dut (
            .CLK(clk), .RST(rst),
            .REQ_VALID(req_valid), .REQ_READY(req_ready[k]), .REQ_WE(req_we),
            .REQ_FUNCT3(req_f3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
            .RESP_VALID(resp_valid[k]), .RESP_READY(resp_ready),
            .RESP_RDATA(resp_rdata[k]), .RESP_ERR(resp_err[k]),
            .MEM_CS(mem_cs[k]), .MEM_WE(mem_we[k]), .MEM_ADDR(mem_addr[k]),
            .MEM_SIZE(mem_size[k]), .MEM_SIGNED(mem_signed[k]), .MEM_DATA(bus)
        );
        assign bus = (mem_cs[k] && !mem_we[k]) ?
                     mem_read(k, mem_addr[k], mem_size[k], mem_signed[k]) : 32'bz;
        assign bus_in[k] = bus;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] ref_rd(input int k, input longint a);
        longint key;
        key = longint'(k) * MEM_BYTES + a;
        return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
    endfunction

    // Reference: spec rules applied to a byte image, little-endian.
    function automatic exp_t model(input int k, input bit we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t   e;
        int     n;
        bit     sg, ok;
        longint v, a;
        ok = 1; sg = 0; n = 1;
        a = longint'({32'd0, addr});
        if (we) begin
            if (f3 <= 3'd2) n = 1 << f3; else ok = 0;
        end else begin
            case (f3)
                3'd0: begin n = 1; sg = 1; end
                3'd1: begin n = 2; sg = 1; end
                3'd2: n = 4;
                3'd4: n = 1;
                3'd5: n = 2;
                default: ok = 0;
            endcase
        end
        e.rdata = 32'd0;
        e.err   = 2'd0;
        e.acc   = 0;
        if (!ok) e.err = 2'd3;
        else if (k == 0 && (a % n) != 0) e.err = 2'd1;
        else if (a + n - 1 > MEM_BYTES - 1) e.err = 2'd2;
        else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[longint'(k) * MEM_BYTES + a + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_rd(k, a + i)) << (8 * i);
            if (sg && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
            e.rdata = v[31:0];
        end
        e.lat = (e.err != 2'd0) ? 1 : 2;
        e.cs  = (e.err != 2'd0) ? 0 : 1;
        return e;
    endfunction

    function automatic bit both_ready();
        return req_ready[0] && req_ready[1];
    endfunction

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!both_ready() && w < 60) begin @(negedge clk); w++; end
        if (w >= 60) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: units not ready after %0d cycles", w);
            return;
        end
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        e = model(0, we, f3, addr, wd); e.acc = cyc; q0.push_back(e);
        e = model(1, we, f3, addr, wd); e.acc = cyc; q1.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        do begin @(negedge clk); w++; end
        while (!(q0.size() == 0 && q1.size() == 0 && both_ready()) && w < 200);
        if (w >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: q0=%0d q1=%0d outstanding", q0.size(), q1.size());
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    // Memory commits stores on the falling edge.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            if (mem_cs[k] && mem_we[k])
                for (int i = 0; i < (1 << mem_size[k]) && i < 4; i++)
                    mem[k][ADDR_W'(mem_addr[k] + i)] = bus_in[k][8*i +: 8];
    end

    // Monitor: pops one expectation on the first cycle each response is valid.
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cs_cnt[k] = 0; seen[k] = 0;
            end else begin
                if (mem_cs[k]) cs_cnt[k]++;
                if (resp_valid[k] && !seen[k]) begin
                    seen[k] = 1;
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_resp%0d: rdata %h err %0d with nothing expected",
                                 k, resp_rdata[k], resp_err[k]);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rdata%0d", k), resp_rdata[k], e.rdata);
                        chk($sformatf("err%0d", k), 32'(resp_err[k]), 32'(e.err));
                        chk($sformatf("latency%0d", k), 32'(cyc - e.acc), 32'(e.lat));
                        chk($sformatf("cs_cycles%0d", k), 32'(cs_cnt[k]), 32'(e.cs));
                    end
                    cs_cnt[k] = 0;
                end
                if (resp_valid[k] && resp_ready) seen[k] = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0;
        int          diffs;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < MEM_BYTES; a++) mem[k][a] = 8'h00;

        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 0);
            chk("rst_resp_valid", 32'(resp_valid[k]), 0);
            chk("rst_rdata", resp_rdata[k], 0);
            chk("rst_err", 32'(resp_err[k]), 0);
            chk("rst_cs", 32'(mem_cs[k]), 0);
            chk("rst_we", 32'(mem_we[k]), 0);
            chk("rst_addr", 32'(mem_addr[k]), 0);
            chk("rst_size", 32'(mem_size[k]), 2);
            chk("rst_signed", 32'(mem_signed[k]), 0);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst0", 32'(req_ready[0]), 1);
        chk("ready_after_rst1", 32'(req_ready[1]), 1);

        issue(1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        drain();
        chk("sw_bytes", {mem[0][32'h103], mem[0][32'h102], mem[0][32'h101], mem[0][32'h100]},
            32'hDEAD_BEEF);
        issue(0, 3'd2, 32'h0000_0100, 32'h0);
        issue(1, 3'd0, 32'h0000_0200, 32'h0000_0080);
        issue(0, 3'd0, 32'h0000_0200, 32'h0);
        issue(0, 3'd4, 32'h0000_0200, 32'h0);
        issue(1, 3'd1, 32'h0000_0200, 32'h0000_8001);
        issue(0, 3'd1, 32'h0000_0200, 32'h0);
        issue(0, 3'd5, 32'h0000_0200, 32'h0);
        issue(0, 3'd2, 32'h0000_0102, 32'h0);
        issue(0, 3'd2, 32'h0010_0000, 32'h0);
        issue(0, 3'd2, 32'h000F_FFFE, 32'h0);
        issue(0, 3'd3, 32'h0000_0100, 32'h0);
        issue(1, 3'd4, 32'h0000_0100, 32'h1111_1111);
        issue(1, 3'd2, 32'h000F_FFFC, 32'hA5C3_0F96);
        issue(0, 3'd2, 32'h000F_FFFC, 32'h0);
        issue(0, 3'd1, 32'h000F_FFFF, 32'h0);
        issue(0, 3'd4, 32'h000F_FFFF, 32'h0);
        drain();

        rr_mode = 2;
        issue(0, 3'd2, 32'h0000_0100, 32'h0);
        begin
            int w;
            w = 0;
            while (!resp_valid[0] && w < 20) begin @(negedge clk); w++; end
            chk("bp_valid_seen", 32'(resp_valid[0]), 1);
        end
        r0 = resp_rdata[0];
        chk("bp_rdata", r0, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2;
                req_addr = 32'h0000_0104; req_wdata = 32'h0000_0BAD;
            end
            if (i == 3) req_valid = 1'b0;
            @(negedge clk);
            chk("bp_valid_hold", 32'(resp_valid[0]), 1);
            chk("bp_rdata_hold", resp_rdata[0], r0);
            chk("bp_req_ready", 32'(req_ready[0]), 0);
        end
        rr_mode = 0;
        @(negedge clk);
        chk("bp_release_valid", 32'(resp_valid[0]), 1);
        @(negedge clk);
        chk("bp_done_valid", 32'(resp_valid[0]), 0);
        chk("bp_done_ready", 32'(req_ready[0]), 1);
        drain();

        rr_mode = 1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'h100 + $urandom_range(0, 32'h2FF);
                1:       a = 32'hF_FFF8 + $urandom_range(0, 7);
                2:       a = 32'h10_0000 | ($urandom() & 32'h3F);
                default: a = $urandom();
            endcase
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
        end
        rr_mode = 0;
        drain();

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2;
        req_addr = 32'h0000_0300; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("mid_cs_before", 32'(mem_cs[0]), 1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_cs", 32'(mem_cs[k]), 0);
            chk("mid_we", 32'(mem_we[k]), 0);
            chk("mid_resp_valid", 32'(resp_valid[k]), 0);
            chk("mid_rdata", resp_rdata[k], 0);
            chk("mid_addr", 32'(mem_addr[k]), 0);
            chk("mid_req_ready", 32'(req_ready[k]), 0);
        end
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("mid_bytes", {mem[k][32'h303], mem[k][32'h302], mem[k][32'h301], mem[k][32'h300]}, 0);
            chk("mid_ready_after", 32'(req_ready[k]), 1);
        end

        for (int k = 0; k < 2; k++) begin
            diffs = 0;
            for (int a = 32'h0F0; a < 32'h410; a++)
                if (mem[k][a] !== ref_rd(k, a)) diffs++;
            chk($sformatf("image_low%0d", k), 32'(diffs), 0);
            diffs = 0;
            for (int a = 32'hF_FFF0; a < MEM_BYTES; a++)
                if (mem[k][a] !== ref_rd(k, a)) diffs++;
            chk($sformatf("image_top%0d", k), 32'(diffs), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
